// File: rtl/fp_div_pkg.sv
// fp_div_pkg: shared FSM state type, single-precision constants and divider sizing.
package fp_div_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DIVIDE, NORM} state_t;
  localparam int EXP_BIAS = 127;
  localparam int QUOT_BITS = 26;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_INF = 32'h7F80_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
endpackage

// File: rtl/fp_div_mant_core.sv
// fp_div_mant_core: restoring mantissa divider, one quotient bit per step.
// Ports: clk, rst (async active-low), load (capture operands, clear quotient),
//        step (retire one quotient bit), dividend/divisor (hidden-1 mantissas),
//        quot (quotient bits, MSB has weight 1), rem (partial remainder, left-shifted).
// The dividend must be below twice the divisor, which holds for normalised mantissas.
module fp_div_mant_core
  import fp_div_pkg::*;
#(
  parameter int MW = 24,
  parameter int QB = QUOT_BITS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [MW-1:0] dividend,
  input  logic [MW-1:0] divisor,
  output logic [QB-1:0] quot,
  output logic [MW:0]   rem
);
  logic [MW-1:0] dvs;
  logic [MW:0] diff;
  logic ge;
  assign ge = rem >= {1'b0, dvs};
  assign diff = rem - {1'b0, dvs};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvs <= '0;
      rem <= '0;
      quot <= '0;
    end else if (load) begin
      dvs <= divisor;
      rem <= {1'b0, dividend};
      quot <= '0;
    end else if (step) begin
      rem <= (ge ? diff : rem) << 1;
      quot <= {quot[QB-2:0], ge};
    end
  end
endmodule

// File: rtl/floating_point_divider_sequential.sv
// floating_point_divider_sequential: fixed 28-cycle IEEE-754 single-precision divider.
// Ports: clk, rst (async active-low), start (accepted only when idle), a/b (dividend/divisor),
//        busy, done (one-cycle pulse), result (held until next done), overflow, div_by_zero.
// Build option: FPDIV_ROUND_EN selects round-to-nearest-even; otherwise the fraction is truncated.
// Denormal inputs are flushed to zero; exponent 255 is treated as an ordinary exponent.
module floating_point_divider_sequential
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [EXP_W+FRAC_W:0]   a,
  input  logic [EXP_W+FRAC_W:0]   b,
  output logic                    busy,
  output logic                    done,
  output logic [EXP_W+FRAC_W:0]   result,
  output logic                    overflow,
  output logic                    div_by_zero
);
  localparam int W = 1 + EXP_W + FRAC_W;
  localparam int MW = FRAC_W + 1;
  localparam int QB = FRAC_W + 3;
  localparam int CW = $clog2(QB);
  localparam int EXP_MAX = (1 << EXP_W) - 2;
`ifdef FPDIV_ROUND_EN
  localparam logic RND_EN = 1'b1;
`else
  localparam logic RND_EN = 1'b0;
`endif
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [W-1:0] a_q, b_q;
  logic [QB-1:0] quot;
  logic [MW:0] rem;
  logic [EXP_W-1:0] ea, eb;
  logic a_zero, b_zero, sign, hi, guard, sticky, rnd, carry, out_range;
  logic [FRAC_W-1:0] frac_t, frac_r;
  logic signed [EXP_W+1:0] exp_t, exp_r;
  logic [W-1:0] res_nxt;
  assign state_nxt = state == IDLE ? (start ? LOAD : IDLE) :
                     state == LOAD ? DIVIDE :
                     state == DIVIDE ? (cnt == CW'(QB - 1) ? NORM : DIVIDE) : IDLE;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      a_q <= '0;
      b_q <= '0;
      done <= 1'b0;
      result <= '0;
      overflow <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= state == DIVIDE ? cnt + 1'b1 : '0;
      done <= state == NORM;
      if (state == IDLE && start) begin
        a_q <= a;
        b_q <= b;
      end
      if (state == NORM) begin
        result <= res_nxt;
        overflow <= !a_zero && !b_zero && out_range;
        div_by_zero <= b_zero;
      end
    end
  end
  fp_div_mant_core #(.MW(MW), .QB(QB)) u_core (
    .clk(clk),
    .rst(rst),
    .load(state == LOAD),
    .step(state == DIVIDE),
    .dividend({1'b1, a_q[FRAC_W-1:0]}),
    .divisor({1'b1, b_q[FRAC_W-1:0]}),
    .quot(quot),
    .rem(rem)
  );
  assign ea = a_q[W-2:FRAC_W];
  assign eb = b_q[W-2:FRAC_W];
  assign a_zero = ea == '0;
  assign b_zero = eb == '0;
  assign sign = a_q[W-1] ^ b_q[W-1];
  // A quotient below 1.0 always has its next bit set, so one left shift normalises it.
  assign hi = quot[QB-1];
  assign frac_t = hi ? quot[QB-2:2] : quot[QB-3:1];
  assign guard = hi ? quot[1] : quot[0];
  assign sticky = (hi & quot[0]) | (|rem);
  assign exp_t = $signed({2'b00, ea}) - $signed({2'b00, eb}) + (EXP_W+2)'(EXP_BIAS) - (EXP_W+2)'(!hi);
  assign rnd = RND_EN & guard & (sticky | frac_t[0]);
  // An all-ones fraction rounding up becomes 1.0 at the next exponent.
  assign {carry, frac_r} = {1'b0, frac_t} + {{FRAC_W{1'b0}}, rnd};
  assign exp_r = exp_t + $signed({{(EXP_W+1){1'b0}}, carry});
  assign out_range = exp_r < 1 || exp_r > EXP_MAX;
  assign res_nxt = b_zero ? (a_zero ? FP_QNAN[W-1:0] : {sign, FP_INF[W-2:0]}) :
                   a_zero ? {sign, FP_ZERO[W-2:0]} : {sign, exp_r[EXP_W-1:0], frac_r};
endmodule

// File: doc/floating_point_divider_sequential.md
FLOATING_POINT_DIVIDER_SEQUENTIAL -- requirements
Module: floating_point_divider_sequential

Interface
REQ-001 Parameter EXP_W SHALL be named EXP_W, default 8, meaning exponent field width.
REQ-002 Parameter FRAC_W SHALL be named FRAC_W, default 23, meaning fraction field width; word width is 1+EXP_W+FRAC_W.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 start  input  1  SHALL request a divide; it is sampled only in IDLE.
REQ-006 a  input  32  SHALL be the dividend, IEEE-754 single format, sampled with start.
REQ-007 b  input  32  SHALL be the divisor, sampled with start.
REQ-008 busy  output  1  SHALL be high from the edge after start is accepted until done.
REQ-009 done  output  1  SHALL be a one-cycle pulse marking result valid.
REQ-010 result  output  32  SHALL be the quotient, held stable from done until the next done.
REQ-011 overflow  output  1  SHALL flag exponent out of range, updated with result.
REQ-012 div_by_zero  output  1  SHALL flag a zero divisor, updated with result.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, DIVIDE, NORM; IDLE->LOAD on start, LOAD->DIVIDE, DIVIDE->NORM after 26 iterations, NORM->IDLE.
REQ-014 Latency SHALL be fixed at 28 cycles: start sampled at edge k gives done high after edge k+28, for all operand values.
REQ-015 start while busy SHALL be ignored; operands and in-flight computation are unaffected.
REQ-016 Sign SHALL be a[31] XOR b[31].
REQ-017 Mantissas (hidden 1 prepended) SHALL be divided by restoring division, one quotient bit per DIVIDE cycle, 26 quotient bits total.
REQ-018 Exponent SHALL be computed 10-bit signed as ea-eb+127, minus 1 when the quotient is below 1.0, which also left-shifts the quotient by 1.
REQ-019 overflow SHALL be 1 when the biased exponent lies outside 1..254; the result exponent field SHALL then be its low 8 bits (wrap, no saturation).
REQ-020 Exponent field 0 SHALL be treated as zero (denormals flushed); exponent 255 SHALL receive no special treatment.
REQ-021 a zero with b nonzero SHALL give result {sign,31'b0}, overflow 0, div_by_zero 0.
REQ-022 b zero with a nonzero SHALL give result {sign,8'hFF,23'h0}, div_by_zero 1, overflow 0.
REQ-023 a and b both zero SHALL give result 32'h7FC00000 and div_by_zero 1.
REQ-024 Without rounding, the fraction SHALL be truncated.

Reset
REQ-025 While rst is low, the FSM SHALL be IDLE, and busy, done, result, overflow and div_by_zero SHALL all be 0.
REQ-026 rst asserted mid-operation SHALL abort the operation with no done pulse; the first start after release SHALL be accepted normally.

Configuration
REQ-027 With FPDIV_ROUND_EN defined, the result SHALL be rounded to nearest-even using the guard bit and a sticky bit (nonzero remainder or extra bits); a mantissa carry-out SHALL increment the exponent before the REQ-019 check.
REQ-028 With FPDIV_ROUND_EN undefined, REQ-024 truncation SHALL apply; latency SHALL be identical in both builds.

Structure
REQ-029 Package fp_div_pkg SHALL hold the FSM state typedef, EXP_BIAS=127, QUOT_BITS=26, and the zero, infinity and quiet-NaN constants.
REQ-030 The iterative mantissa divider SHALL be sub-module fp_div_mant_core, with a load/step interface plus quotient and remainder outputs.

Verification
REQ-031 a=32'h41200000, b=32'h40000000, start -> done after exactly 28 edges, result 32'h40A00000, flags 0.
REQ-032 a=32'h3F800000, b=32'h40400000 -> result 32'h3EAAAAAA without FPDIV_ROUND_EN, 32'h3EAAAAAB with it.
REQ-033 a=32'hC0000000, b=32'h00000000 -> result 32'hFF800000, div_by_zero 1; a=b=0 -> result 32'h7FC00000.
REQ-034 a=32'h7F000000, b=32'h00800000 -> result 32'h3E000000, overflow 1.
REQ-035 start pulsed again at cycle 5 of a divide -> ignored: single done, first result correct.
REQ-036 rst low at cycle 10 of a divide -> outputs 0, no done; a new divide after release completes correctly.
